// File: rtl/seg7_fmt_pkg.sv
// Shared types and constants for the seven-segment number formatter.
package seg7_fmt_pkg;

    localparam int CONV_BITS = 27;
    localparam int DIGITS    = 8;

    localparam logic [CONV_BITS-1:0] DEC_MAX  = 27'd99_999_999;
    localparam logic [31:0]          OVF_WORD = 32'hEEEE_EEEE;
    localparam logic [31:0]          SAT_WORD = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } fmt_state_t;

endpackage

// File: rtl/seg7_num_fmt_if.sv
// Write strobe and display outputs between the register block and the formatter.
interface seg7_num_fmt_if;

    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_dec;
    logic [31:0] disp_word;
    logic        disp_valid;
    logic        busy;
    logic        ovf;

    modport master (
        output wr_en, wr_data, wr_dec,
        input  disp_word, disp_valid, busy, ovf
    );

    modport slave (
        input  wr_en, wr_data, wr_dec,
        output disp_word, disp_valid, busy, ovf
    );

endinterface

// File: rtl/seg7_bcd_adj3.sv
// One double-dabble correction step for a single BCD digit: add 3 when the digit is 5 or more.
module seg7_bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] digit_adj
);

    assign digit_adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seg7_num_fmt.sv
// Formats a written value as hex or 8-digit BCD and publishes it atomically to the display.
// Build option SEG7_FMT_SAT_EN: decimal overflow shows 9999_9999 instead of EEEE_EEEE.
//
// state | meaning
// IDLE  | no conversion in flight, disp_word holding
// CONV  | one double-dabble iteration per cycle
// LOAD  | publish the finished BCD word
module seg7_num_fmt
    import seg7_fmt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seg7_num_fmt_if.slave bus
);

`ifdef SEG7_FMT_SAT_EN
    localparam logic [31:0] OVF_SHOW = SAT_WORD;
`else
    localparam logic [31:0] OVF_SHOW = OVF_WORD;
`endif

    localparam logic [4:0] LAST_ITER = 5'(CONV_BITS - 1);

    fmt_state_t              state, state_nx;
    logic [CONV_BITS-1:0]    bin_sr, bin_nx;
    logic [4*DIGITS-1:0]     bcd_sr, bcd_nx, bcd_adj;
    logic [4:0]              cnt, cnt_nx;
    logic [31:0]             word_q, word_nx;
    logic                    valid_q, valid_nx;
    logic                    ovf_q, ovf_nx;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        seg7_bcd_adj3 u_adj (
            .digit     (bcd_sr[4*d +: 4]),
            .digit_adj (bcd_adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            bin_sr  <= bin_nx;
            bcd_sr  <= bcd_nx;
            cnt     <= cnt_nx;
            word_q  <= word_nx;
            valid_q <= valid_nx;
            ovf_q   <= ovf_nx;
        end
    end

    // A write always takes priority over the engine, so an in-flight result is simply dropped.
    always_comb begin
        state_nx = state;
        bin_nx   = bin_sr;
        bcd_nx   = bcd_sr;
        cnt_nx   = cnt;
        word_nx  = word_q;
        valid_nx = 1'b0;
        ovf_nx   = ovf_q;
        if (bus.wr_en) begin
            if (!bus.wr_dec) begin
                word_nx  = bus.wr_data;
                valid_nx = 1'b1;
                ovf_nx   = 1'b0;
                state_nx = IDLE;
            end else if (bus.wr_data > {5'd0, DEC_MAX}) begin
                word_nx  = OVF_SHOW;
                valid_nx = 1'b1;
                ovf_nx   = 1'b1;
                state_nx = IDLE;
            end else begin
                bin_nx   = bus.wr_data[CONV_BITS-1:0];
                bcd_nx   = '0;
                cnt_nx   = '0;
                ovf_nx   = 1'b0;
                state_nx = CONV;
            end
        end else begin
            unique case (state)
                CONV: begin
                    bcd_nx = {bcd_adj[4*DIGITS-2:0], bin_sr[CONV_BITS-1]};
                    bin_nx = {bin_sr[CONV_BITS-2:0], 1'b0};
                    cnt_nx = cnt + 5'd1;
                    if (cnt == LAST_ITER) state_nx = LOAD;
                end
                LOAD: begin
                    word_nx  = bcd_sr;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                end
                default: ;
            endcase
        end
    end

    assign bus.disp_word  = word_q;
    assign bus.disp_valid = valid_q;
    assign bus.busy       = (state != IDLE);
    assign bus.ovf        = ovf_q;

endmodule
